// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int FPGAClkSpeed  = 100000000,
  parameter int BaudRate      = 230400,
  parameter int FifoDepthLog2 = 4,
  parameter int data_width    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    uart_rx_i,
  input  logic                    rd_en_i,
  input  logic                    clr_err_i,
  output logic [data_width-1:0]   rd_data_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [FifoDepthLog2:0]  count_o,
  output logic                    frame_err_o,
  output logic                    overrun_o
);
  localparam int ClksPerBit = (FPGAClkSpeed + BaudRate / 2) / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CW         = $clog2(ClksPerBit + 1);
  localparam int BW         = $clog2(data_width);
  localparam int NW         = FifoDepthLog2 + 1;
  localparam int Depth      = 1 << FifoDepthLog2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t                   state;
  logic                     rx_meta, rxs;
  logic [2:0]               warm;
  logic [CW-1:0]            clk_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [data_width-1:0]    shreg;
  logic [data_width-1:0]    mem [Depth];
  logic [FifoDepthLog2-1:0] wr_ptr, rd_ptr;
  logic                     stop_hit, push, pop;
  logic [NW-1:0]            count_n;
  always_comb begin
    stop_hit = state == STOP && clk_cnt == CW'(ClksPerBit - 1);
    pop      = rd_en_i && !empty_o;
    push     = stop_hit && rxs && (!full_o || pop);
    count_n  = count_o + NW'(push) - NW'(pop);
  end
  // warm[1] & ~warm[2] marks the first cycle rxs reflects the real line after reset
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      warm        <= '0;
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta     <= uart_rx_i;
      rxs         <= rx_meta;
      warm        <= {warm[1:0], 1'b1};
      clk_cnt     <= clk_cnt + CW'(1);
      frame_err_o <= (frame_err_o && !clr_err_i) || (stop_hit && !rxs);
      overrun_o   <= (overrun_o && !clr_err_i) || (stop_hit && rxs && full_o && !pop);
      case (state)
        IDLE: if (!rxs) begin
          state   <= warm[1] && !warm[2] ? BREAK : START;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
        START: if (clk_cnt == CW'(HalfBit - 1)) begin
          state   <= rxs ? IDLE : DATA;
          clk_cnt <= '0;
        end
        DATA: if (clk_cnt == CW'(ClksPerBit - 1)) begin
          shreg   <= {rxs, shreg[data_width-1:1]};
          clk_cnt <= '0;
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(data_width - 1)) state <= STOP;
        end
        STOP: if (stop_hit) state <= rxs ? IDLE : BREAK;
        BREAK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FifoDepthLog2'(1);
      if (pop) rd_ptr <= rd_ptr + FifoDepthLog2'(1);
      count_o <= count_n;
      empty_o <= count_n == '0;
      full_o  <= count_n == NW'(Depth);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= shreg;
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the UART receiver and its FIFO at 16 clocks per bit
module tb_uart_rx_fifo;
  logic       clk = 1'b0, reset_n = 1'b0, uart_rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, frame_err, overrun;
  logic [7:0] c3 = 8'hC3;
  int         n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(
    .FPGAClkSpeed(1600000), .BaudRate(100000), .FifoDepthLog2(4), .data_width(8)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .uart_rx_i(uart_rx), .rd_en_i(rd_en), .clr_err_i(clr_err),
    .rd_data_o(rd_data), .empty_o(empty), .full_o(full), .count_o(count),
    .frame_err_o(frame_err), .overrun_o(overrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic good, input int pop_at);
    for (int k = 0; k < 200; k++) begin
      int j;
      j = k / 16;
      uart_rx = j == 0 ? 1'b0 : j <= 8 ? b[j-1] : j == 9 ? good : 1'b1;
      rd_en = k == pop_at;
      @(negedge clk);
    end
  endtask
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", rd_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hA5, 1'b1, -1);
    check("a5_count", count, 1);
    check("a5_head", rd_data, 8'hA5);
    send(8'h00, 1'b1, -1);
    check("00_count", count, 2);
    send(8'hFF, 1'b1, -1);
    check("ff_count", count, 3);
    check("valid_fe", frame_err, 0);
    check("valid_ov", overrun, 0);
    pop_check("pop_a5", 8'hA5);
    pop_check("pop_00", 8'h00);
    pop_check("pop_ff", 8'hFF);
    check("valid_empty", empty, 1);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_empty", empty, 1);
    send(8'h3C, 1'b1, -1);
    check("glitch_count", count, 1);
    pop_check("glitch_3c", 8'h3C);
    send(8'h3C, 1'b0, -1);
    check("ferr_flag", frame_err, 1);
    check("ferr_empty", empty, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ferr_clr", frame_err, 0);
    send(8'h55, 1'b1, -1);
    pop_check("ferr_55", 8'h55);
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1, -1);
    check("fill_full", full, 1);
    check("fill_ov", overrun, 0);
    send(8'h11, 1'b1, -1);
    check("ovr_flag", overrun, 1);
    check("ovr_count", count, 16);
    check("ovr_full", full, 1);
    for (int i = 1; i <= 16; i++) pop_check("ovr_pop", 8'(i));
    check("ovr_empty", empty, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_clr", overrun, 0);
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1, -1);
    check("sim_head", rd_data, 8'h20);
    send(8'h30, 1'b1, 154);
    check("sim_count", count, 16);
    check("sim_full", full, 1);
    check("sim_ov", overrun, 0);
    for (int i = 0; i < 16; i++) pop_check("sim_pop", i == 15 ? 8'h30 : 8'h21 + 8'(i));
    check("sim_empty", empty, 1);
    send(8'h3C, 1'b0, -1);
    send(8'h77, 1'b1, -1);
    check("pre_rst_count", count, 1);
    check("pre_rst_fe", frame_err, 1);
    for (int k = 0; k < 200; k++) begin
      int j;
      j = k / 16;
      uart_rx = j == 0 ? 1'b0 : j <= 8 ? c3[j-1] : 1'b1;
      if (k == 88) reset_n = 1'b0;
      if (k == 92) begin
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_fe", frame_err, 0);
        reset_n = 1'b1;
      end
      @(negedge clk);
    end
    check("post_rst_empty", empty, 1);
    send(8'h81, 1'b1, -1);
    check("post_rst_count", count, 1);
    pop_check("post_rst_81", 8'h81);
    check("post_rst_fe", frame_err, 0);
    check("final_empty", empty, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a receive FIFO: the inbound partner of the CPU UART transmitter. It deserializes 8N1 frames from `uart_rx_i` at a fixed baud rate and buffers the received bytes in a first-word-fall-through FIFO. The 6502 bus-peripheral layer drains the FIFO through a pop strobe and reads sticky error flags from this block.

## Interface
Parameters:
- `FPGAClkSpeed`, 100000000, clock frequency in Hz
- `BaudRate`, 230400, line rate in bit/s
- `FifoDepthLog2`, 4, FIFO depth = 2^FifoDepthLog2 entries
- `data_width`, 8, frame data bits (fixed at 8 for 8N1)

Ports:
- `clk_i`  in  1  system clock
- `reset_ni`  in  1  asynchronous active-low reset
- `uart_rx_i`  in  1  serial line; asynchronous to `clk_i`; idle high
- `rd_en_i`  in  1  pop strobe; one entry popped per cycle while high and `empty_o`=0
- `clr_err_i`  in  1  clears `frame_err_o` and `overrun_o`
- `rd_data_o`  out  data_width  FIFO head, valid while `empty_o`=0
- `empty_o`  out  1  FIFO empty
- `full_o`  out  1  FIFO full
- `count_o`  out  FifoDepthLog2+1  entries held
- `frame_err_o`  out  1  sticky: stop bit sampled low
- `overrun_o`  out  1  sticky: byte dropped because FIFO full

## Operation
- Derived constant: ClksPerBit = (FPGAClkSpeed + BaudRate/2) / BaudRate (434 at defaults); HalfBit = ClksPerBit/2 (217).
- `uart_rx_i` passes through a 2-FF synchronizer with reset value 1. The receiver uses only the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rxs`=0, go to START and clear the bit counter.
  - START: after HalfBit cycles, sample `rxs`. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: every ClksPerBit cycles, sample `rxs` into the shift register, LSB first. After 8 samples, go to STOP.
  - STOP: after ClksPerBit cycles, sample `rxs`.
    - If 1: push the byte (or set `overrun_o` if the FIFO is full and no pop occurs that cycle), then go to IDLE.
    - If 0: set `frame_err_o`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE.
- The STOP sample is taken mid stop bit. A start edge arriving after that sample is accepted.
- FIFO behaviour:
  - Circular buffer with FifoDepthLog2-bit read and write pointers that wrap modulo depth.
  - `count_o` is an explicit counter.
  - A pop while empty is ignored.
  - Push and pop in the same cycle: both occur and `count_o` is unchanged, including when full. In that case no overrun is flagged.
- `clr_err_i` clears both sticky flags. If a new error occurs in the same cycle, setting wins.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties and the flags clear. After reset release, a line that is already low is treated as a start edge only after `rxs` reads high at least once: the FSM enters BREAK on reset if `rxs`=0.

## Timing
- Reset values:
  - `rd_data_o`=0, `empty_o`=1, `full_o`=0, `count_o`=0, `frame_err_o`=0, `overrun_o`=0
  - FSM in IDLE, synchronizer=1
- Input latency: a `uart_rx_i` change reaches `rxs` 2 cycles later.
- Sample points, counted from the first cycle `rxs`=0:
  - start bit at HalfBit
  - data bit k at HalfBit + (k+1)·ClksPerBit
  - stop bit at HalfBit + 9·ClksPerBit
- Push latency: `empty_o` falls and `count_o` increments on the clock edge after the stop sample cycle. `rd_data_o` shows the byte the same cycle.
- Pop: `rd_data_o` advances to the next entry and `count_o` decrements on the edge where `rd_en_i`=1. `empty_o` rises on that edge if this was the last entry.
- `full_o` = (`count_o` == 2^FifoDepthLog2). `empty_o` = (`count_o` == 0). Both are registered together with `count_o`.
- Error flags rise on the edge after the offending stop sample.

## Test plan
- Valid frame: send 0xA5 at 230400 baud, then 0x00, then 0xFF → FIFO pops 0xA5, 0x00, 0xFF in order. `count_o` goes 1→2→3. No flags set.
- Glitch rejection: drive `uart_rx_i` low for 100 cycles, then high → no push, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing error: send 0x3C with the stop bit held 0 for one bit, then high → `frame_err_o`=1, `empty_o`=1. Pulse `clr_err_i` → `frame_err_o`=0. A following 0x55 is received.
- Overrun: send 17 bytes 0x01..0x11 with no pops → `full_o`=1, `count_o`=16, `overrun_o`=1. Pops return 0x01..0x10.
- Full with simultaneous push and pop: hold `rd_en_i`=1 exactly on the push cycle while full → `count_o` stays 16, `overrun_o`=0, and the newest byte lands last.
- Reset mid-frame: assert `reset_ni` low during data bit 4 of 0xC3 → all outputs return to reset values. After release, a full 0x81 frame is received as 0x81 only.
